// File: rtl/wb_commit_arbiter_pkg.sv
// Shared definitions for the writeback commit arbiter: state encodings and the
// per-lane control bundle.
package wb_commit_arbiter_pkg;

  typedef enum logic [1:0] {
    WB_ST_IDLE  = 2'd0,
    WB_ST_HOLD  = 2'd1,
    WB_ST_FLUSH = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic valid;
    logic excep;
    logic ertn;
    logic csrw;
  } wb_lane_t;

  localparam int WB_LANE_W = $bits(wb_lane_t);

  // ertn and exception both redirect the front end, so they share one event flag
  function automatic logic wb_lane_event(input wb_lane_t lane);
    return lane.valid & (lane.excep | lane.ertn);
  endfunction

endpackage

// File: rtl/wb_commit_arbiter.sv
// Commit controller for the dual-issue WB stage: arbitrates the shared CSR/llbit/exception
// port between the two lanes and sequences the flush window after an exception or ertn.
module wb_commit_arbiter
  import wb_commit_arbiter_pkg::*;
#(
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rfb_allowin_i,
  input  logic l0_valid_i,
  input  logic l0_excep_i,
  input  logic l0_ertn_i,
  input  logic l0_csrw_i,
  input  logic l1_valid_i,
  input  logic l1_excep_i,
  input  logic l1_ertn_i,
  input  logic l1_csrw_i,
  output logic l0_commit_o,
  output logic l1_commit_o,
  output logic csr_sel_o,
  output logic excep_fire_o,
  output logic flush_o,
  output logic wb_allowin_o
);

  wb_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  wb_lane_t         l0, l1;
  logic             ev0, ev1, conflict;

  assign l0 = '{valid: l0_valid_i, excep: l0_excep_i, ertn: l0_ertn_i, csrw: l0_csrw_i};
  assign l1 = '{valid: l1_valid_i, excep: l1_excep_i, ertn: l1_ertn_i, csrw: l1_csrw_i};

  assign ev0      = wb_lane_event(l0);
  assign ev1      = wb_lane_event(l1);
  assign conflict = l0.valid & l1.valid & l0.csrw & l1.csrw & ~ev0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WB_ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    l0_commit_o  = 1'b0;
    l1_commit_o  = 1'b0;
    csr_sel_o    = 1'b0;
    excep_fire_o = 1'b0;
    flush_o      = 1'b0;
    wb_allowin_o = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;

    case (state)
      WB_ST_IDLE: begin
        if (rfb_allowin_i) begin
          l0_commit_o  = l0.valid & ~ev0;
          l1_commit_o  = l1.valid & ~ev0 & ~ev1 & ~conflict;
          excep_fire_o = ev0 | (ev1 & ~conflict);
          csr_sel_o    = ~ev0 & (ev1 | (~l0.csrw & l1.csrw));
          flush_o      = excep_fire_o;
          // Holding the pair in place lets lane1 retry the port next cycle
          wb_allowin_o = ~conflict;
          if (excep_fire_o) begin
            state_nxt = WB_ST_FLUSH;
            cnt_nxt   = CNT_W'(FLUSH_CYC - 1);
          end else if (conflict) begin
            state_nxt = WB_ST_HOLD;
          end
        end
      end

      WB_ST_HOLD: begin
        csr_sel_o = 1'b1;
        if (rfb_allowin_i) begin
          l1_commit_o  = ~ev1;
          excep_fire_o = ev1;
          flush_o      = ev1;
          wb_allowin_o = 1'b1;
          if (ev1) begin
            state_nxt = WB_ST_FLUSH;
            cnt_nxt   = CNT_W'(FLUSH_CYC - 1);
          end else begin
            state_nxt = WB_ST_IDLE;
          end
        end
      end

      WB_ST_FLUSH: begin
        flush_o      = 1'b1;
        wb_allowin_o = 1'b1;
        if (cnt == '0) begin
          state_nxt = WB_ST_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end

      default: begin
        state_nxt = WB_ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Randomized self-checking bench for wb_commit_arbiter against a behavioural model
// that tracks a pending-lane1 flag and the number of flush cycles still owed.
module tb_wb_commit_arbiter;

  localparam int FLUSH_CYC = 2;

  localparam bit [3:0] NONE  = 4'b0000;
  localparam bit [3:0] PLAIN = 4'b1000;
  localparam bit [3:0] CSRW  = 4'b1001;
  localparam bit [3:0] EXC   = 4'b1100;
  localparam bit [3:0] ERTN  = 4'b1010;

  logic clk = 1'b0;
  logic rst;
  logic rfb_allowin_i;
  logic l0_valid_i, l0_excep_i, l0_ertn_i, l0_csrw_i;
  logic l1_valid_i, l1_excep_i, l1_ertn_i, l1_csrw_i;
  logic l0_commit_o, l1_commit_o, csr_sel_o, excep_fire_o, flush_o, wb_allowin_o;

  int checks = 0;
  int errors = 0;

  // Model state: lane1 still owed the port, and flush cycles left after the firing cycle
  bit holding = 1'b0;
  int flushLeft = 0;

  wb_commit_arbiter #(.FLUSH_CYC(FLUSH_CYC), .CNT_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .rfb_allowin_i(rfb_allowin_i),
    .l0_valid_i   (l0_valid_i),
    .l0_excep_i   (l0_excep_i),
    .l0_ertn_i    (l0_ertn_i),
    .l0_csrw_i    (l0_csrw_i),
    .l1_valid_i   (l1_valid_i),
    .l1_excep_i   (l1_excep_i),
    .l1_ertn_i    (l1_ertn_i),
    .l1_csrw_i    (l1_csrw_i),
    .l0_commit_o  (l0_commit_o),
    .l1_commit_o  (l1_commit_o),
    .csr_sel_o    (csr_sel_o),
    .excep_fire_o (excep_fire_o),
    .flush_o      (flush_o),
    .wb_allowin_o (wb_allowin_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic obs, input logic expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Drive one cycle of inputs (lane bits are {valid, excep, ertn, csrw}), check the
  // outputs mid-cycle against the model, then advance the model across the clock edge.
  task automatic applyStimulus(input bit r, input bit rfb, input bit [3:0] a, input bit [3:0] b);
    bit ev0, ev1, conf, selCare;
    bit eL0, eL1, eSel, eFire, eFlush, eAllow;
    rst           = r;
    rfb_allowin_i = rfb;
    {l0_valid_i, l0_excep_i, l0_ertn_i, l0_csrw_i} = a;
    {l1_valid_i, l1_excep_i, l1_ertn_i, l1_csrw_i} = b;

    ev0  = a[3] & (a[2] | a[1]);
    ev1  = b[3] & (b[2] | b[1]);
    conf = a[3] & b[3] & a[0] & b[0] & !ev0;
    {eL0, eL1, eSel, eFire, eFlush, eAllow} = '0;
    selCare = 1'b1;

    if (flushLeft > 0) begin
      eFlush = 1'b1;
      eAllow = 1'b1;
    end else if (!rfb) begin
      selCare = 1'b0;
    end else if (holding) begin
      eSel   = 1'b1;
      eL1    = !ev1;
      eFire  = ev1;
      eFlush = ev1;
      eAllow = 1'b1;
    end else begin
      eL0    = a[3] & !ev0;
      eL1    = b[3] & !ev0 & !ev1 & !conf;
      eFire  = ev0 | (ev1 & !conf);
      eSel   = !ev0 & (ev1 | (!a[0] & b[0]));
      eFlush = eFire;
      eAllow = !conf;
    end

    @(negedge clk);
    checkOutput("l0_commit", l0_commit_o, eL0);
    checkOutput("l1_commit", l1_commit_o, eL1);
    checkOutput("excep_fire", excep_fire_o, eFire);
    checkOutput("flush", flush_o, eFlush);
    checkOutput("wb_allowin", wb_allowin_o, eAllow);
    if (selCare) checkOutput("csr_sel", csr_sel_o, eSel);

    @(posedge clk);
    if (r) begin
      holding   = 1'b0;
      flushLeft = 0;
    end else if (flushLeft > 0) begin
      flushLeft--;
    end else if (rfb) begin
      holding = !holding && conf;
      if (eFire) flushLeft = FLUSH_CYC;
    end
    #1;
  endtask

  function automatic bit [3:0] randLane();
    bit [3:0] l;
    l[3] = ($urandom_range(0, 9) < 8);
    l[2] = ($urandom_range(0, 9) == 0);
    l[1] = ($urandom_range(0, 12) == 0);
    l[0] = ($urandom_range(0, 9) < 4);
    return l;
  endfunction

  initial begin
    rst = 1'b1;
    rfb_allowin_i = 1'b0;
    {l0_valid_i, l0_excep_i, l0_ertn_i, l0_csrw_i} = '0;
    {l1_valid_i, l1_excep_i, l1_ertn_i, l1_csrw_i} = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: outputs quiet, allowin follows the regfile stage
    applyStimulus(0, 1, NONE, NONE);
    applyStimulus(0, 0, NONE, NONE);

    // Both lanes retire together
    applyStimulus(0, 1, PLAIN, PLAIN);
    applyStimulus(0, 1, PLAIN, CSRW);

    // CSR conflict: lane0 first, lane1 next cycle, then back to idle
    applyStimulus(0, 1, CSRW, CSRW);
    applyStimulus(0, 1, CSRW, CSRW);
    applyStimulus(0, 1, PLAIN, PLAIN);

    // Older exception with flush window
    applyStimulus(0, 1, EXC, PLAIN);
    applyStimulus(0, 1, PLAIN, PLAIN);
    applyStimulus(0, 0, PLAIN, PLAIN);
    applyStimulus(0, 1, PLAIN, PLAIN);

    // Younger ertn, and simultaneous events where lane0 wins
    applyStimulus(0, 1, PLAIN, ERTN);
    applyStimulus(0, 1, NONE, NONE);
    applyStimulus(0, 1, NONE, NONE);
    applyStimulus(0, 1, ERTN, EXC);
    applyStimulus(0, 1, NONE, NONE);
    applyStimulus(0, 1, NONE, NONE);

    // Backpressure during the lane1 hold
    applyStimulus(0, 1, CSRW, CSRW);
    repeat (3) applyStimulus(0, 0, CSRW, CSRW);
    applyStimulus(0, 1, CSRW, CSRW);

    // Conflict where the held lane1 then raises an exception
    applyStimulus(0, 1, CSRW, CSRW | EXC);
    applyStimulus(0, 1, CSRW, CSRW | EXC);
    applyStimulus(0, 1, NONE, NONE);
    applyStimulus(0, 1, NONE, NONE);

    // Reset in the middle of the flush window
    applyStimulus(0, 1, EXC, NONE);
    applyStimulus(1, 1, NONE, NONE);
    applyStimulus(0, 1, NONE, NONE);
    applyStimulus(0, 0, PLAIN, NONE);

    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                    randLane(), randLane());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
